// File: rtl/spi_pkg.sv
// Purpose : shared types and defaults for the SPI slave receiver slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  typedef enum logic {IDLE, RECV} spi_rx_state_e;

  localparam int SPI_DATA_W_DEFAULT = 8;
  localparam int SPI_SYNC_MIN       = 2;

endpackage

// File: rtl/spi_sync.sv
// Purpose : brings one asynchronous pin into clk_i and flags its edges.
// Latency : SYNC_STAGES + 1 clk_i cycles from pin to o_level/o_rise/o_fall.
// Backpressure: none; pulses are one cycle wide and must be consumed immediately.
// Ports   : clk_i, rst_ni (async active-low), i_async (raw pin),
//           o_level (synchronised level), o_rise/o_fall (one-cycle edge pulses).
module spi_sync
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SPI_SYNC_MIN,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   r_rise;
  logic                   r_fall;

  // r_edge is the edge-detect flop; the pulses are registered so that in the
  // cycle a pulse is high, o_level already shows the new level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_edge <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_edge <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_edge;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_edge;
    end
  end

  assign o_level = r_edge;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_rx.sv
// Purpose : SPI mode-0 slave receiver; deserialises MOSI into DATA_W-bit words.
// Latency : ack_o SYNC_STAGES+2 clk_i cycles (+1 sync uncertainty) after the last SCLK rise.
// Backpressure: none; downstream must take data_o in the ack_o cycle (data_o then holds).
// Ports   : clk_i, rst_ni, spi_sclk_i, spi_cs_ni, spi_mosi_i -> data_o, ack_o,
//           busy_o, frame_err_o, spi_miso_o.
// Option  : define SPI_MISO_ECHO_EN to echo the last word on spi_miso_o.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_ni,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_async(spi_sclk_i),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_async(spi_cs_ni),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  // mosi goes through an identical chain so its level lines up with sclk_rise.
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_async(spi_mosi_i),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  logic w_unused_sync;
  assign w_unused_sync = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall, w_sclk_fall};

  spi_rx_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_ferr, w_ferr_nxt;
  logic              w_last;

  assign w_shift_in = MSB_FIRST ? {r_shift[DATA_W-2:0], w_mosi}
                                : {w_mosi, r_shift[DATA_W-1:1]};
  assign w_last     = (r_cnt == LAST_BIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_ack   <= w_ack_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_ack_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      RECV: begin
        // The sample is taken before CS rise is considered, so a word whose
        // last bit coincides with CS rise still completes cleanly.
        if (w_sclk_rise) begin
          w_shift_nxt = w_shift_in;
          if (w_last) begin
            w_data_nxt = w_shift_in;
            w_ack_nxt  = 1'b1;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ferr_nxt  = w_sclk_rise ? !w_last : (r_cnt != '0);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_o      = r_data;
  assign ack_o       = r_ack;
  assign frame_err_o = r_ferr;
  assign busy_o      = (r_state == RECV);

`ifdef SPI_MISO_ECHO_EN
  logic [DATA_W-1:0] r_tx;

  // Reloaded at frame start and after every completed word, so the master
  // reads back the most recent word on the following transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx <= '0;
    end else if ((r_state == IDLE) && w_cs_fall) begin
      r_tx <= r_data;
    end else if (r_ack) begin
      r_tx <= r_data;
    end else if ((r_state == RECV) && w_sclk_fall) begin
      r_tx <= MSB_FIRST ? {r_tx[DATA_W-2:0], 1'b0} : {1'b0, r_tx[DATA_W-1:1]};
    end
  end

  assign spi_miso_o = (r_state == RECV) & (MSB_FIRST ? r_tx[DATA_W-1] : r_tx[0]);
`else
  assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Purpose : directed bench for spi_slave_rx (MSB-first and LSB-first instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_spi_slave_rx;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso, miso_lsb;
  logic [7:0] data, data_lsb;
  logic       ack, ack_lsb;
  logic       busy, busy_lsb;
  logic       ferr, ferr_lsb;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .spi_sclk_i(sclk), .spi_cs_ni(cs_n),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .data_o(data), .ack_o(ack),
    .busy_o(busy), .frame_err_o(ferr));

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i(clk), .rst_ni(rst_n), .spi_sclk_i(sclk), .spi_cs_ni(cs_n),
    .spi_mosi_i(mosi), .spi_miso_o(miso_lsb), .data_o(data_lsb), .ack_o(ack_lsb),
    .busy_o(busy_lsb), .frame_err_o(ferr_lsb));

  // Pulse monitors, sampled mid-cycle.
  int         ack_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         busy_drop = 0;
  bit         in_frame = 1'b0;
  logic [7:0] ack_q[$];

  always @(negedge clk) begin
    if (ack) begin
      ack_cnt++;
      ack_q.push_back(data);
    end
    if (ferr) ferr_cnt++;
    if (ack && ferr) both_cnt++;
    if (ack_lsb && ferr_lsb) both_cnt++;
    if (in_frame && !busy) busy_drop++;
  end

  typedef struct {
    logic [7:0] tx;
    int         nbits;
    int         exp_ack;
    int         exp_ferr;
    logic [7:0] exp_data;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    cs_n = 1'b1;
    tick(10);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO captured just before each rise.
  task automatic send_bits(input logic [7:0] val, input int nbits, input int half,
                           output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = val[7-i];
      tick(half);
      cap  = {cap[6:0], miso};
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  initial begin
    int         a0, f0;
    logic [7:0] cap;
    logic [7:0] exp_echo;

    vecs[0] = '{8'hA5, 8, 1, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'h80, 8, 1, 0, 8'h80, 8'h01};
    vecs[2] = '{8'h5A, 8, 1, 0, 8'h5A, 8'h5A};
    vecs[3] = '{8'hF0, 5, 0, 1, 8'h5A, 8'h5A};  // aborted word
    vecs[4] = '{8'h00, 0, 0, 0, 8'h5A, 8'h5A};  // empty frame
    vecs[5] = '{8'hFF, 8, 1, 0, 8'hFF, 8'hFF};

    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    tick(5);
    check("rst_data", 32'(data), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_miso", 32'(miso), 32'h0);
    rst_n = 1'b1;
    tick(5);

    for (int v = 0; v < 6; v++) begin
      a0 = ack_cnt;
      f0 = ferr_cnt;
      cs_low();
      check($sformatf("v%0d_busy_open", v), 32'(busy), 32'h1);
      send_bits(vecs[v].tx, vecs[v].nbits, 4, cap);
      cs_high();
      check($sformatf("v%0d_acks", v), 32'(ack_cnt - a0), 32'(vecs[v].exp_ack));
      check($sformatf("v%0d_ferrs", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      check($sformatf("v%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_data_lsb", v), 32'(data_lsb), 32'(vecs[v].exp_lsb));
      check($sformatf("v%0d_busy_closed", v), 32'(busy), 32'h0);
    end

    // Multi-byte frame under one CS.
    ack_q.delete();
    f0 = ferr_cnt;
    busy_drop = 0;
    cs_low();
    in_frame = 1'b1;
    send_bits(8'h3C, 8, 4, cap);
    send_bits(8'hFF, 8, 4, cap);
    send_bits(8'h00, 8, 4, cap);
    tick(8);
    in_frame = 1'b0;
    cs_high();
    check("multi_count", 32'(ack_q.size()), 32'd3);
    if (ack_q.size() == 3) begin
      check("multi_b0", 32'(ack_q[0]), 32'h3C);
      check("multi_b1", 32'(ack_q[1]), 32'hFF);
      check("multi_b2", 32'(ack_q[2]), 32'h00);
    end
    check("multi_busy_drop", 32'(busy_drop), 32'h0);
    check("multi_ferr", 32'(ferr_cnt - f0), 32'h0);

    // Set a known word, then reset mid-word.
    send_bits(8'h00, 0, 4, cap);
    cs_low();
    send_bits(8'h6E, 8, 4, cap);
    cs_high();
    check("pre_reset_data", 32'(data), 32'h6E);
    a0 = ack_cnt;
    f0 = ferr_cnt;
    cs_low();
    send_bits(8'hF0, 4, 4, cap);
    rst_n = 1'b0;
    tick(1);
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ack", 32'(ack), 32'h0);
    cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    check("postrst_acks", 32'(ack_cnt - a0), 32'h0);
    check("postrst_ferrs", 32'(ferr_cnt - f0), 32'h0);
    cs_low();
    send_bits(8'h81, 8, 4, cap);
    cs_high();
    check("rst_recover_acks", 32'(ack_cnt - a0), 32'h1);
    check("rst_recover_data", 32'(data), 32'h81);
    check("rst_recover_lsb", 32'(data_lsb), 32'h81);
    check("rst_recover_ferrs", 32'(ferr_cnt - f0), 32'h0);

    // MISO echo: load 0xC3, then read it back on the next frame.
    cs_low();
    send_bits(8'hC3, 8, 4, cap);
    cs_high();
    check("echo_src_data", 32'(data), 32'hC3);
    check("idle_miso", 32'(miso), 32'h0);
    cs_low();
    send_bits(8'h00, 8, 8, cap);
    cs_high();
`ifdef SPI_MISO_ECHO_EN
    exp_echo = 8'hC3;
`else
    exp_echo = 8'h00;
`endif
    check("echo_readback", 32'(cap), 32'(exp_echo));
    check("ack_ferr_overlap", 32'(both_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI slave receiver, mode 0 (CPOL=0, CPHA=0).
- Brings the asynchronous SPI pins into the clk_i domain and deserialises MOSI into bytes.
- Emits each completed byte with a one-cycle acknowledge pulse.
- Sits directly upstream of the LED output register: data_o/ack_o connect straight to that stage's data/ack inputs.

Parameters:
- DATA_W, 8: bits per word; width of data_o and of the shift register.
- SYNC_STAGES, 2: flip-flop depth of each pin synchroniser; legal range 2..4.
- MSB_FIRST, 1: 1 means the first SCLK bit lands in data_o[DATA_W-1]; 0 means it lands in data_o[0].

Ports:
- clk_i  input  1  system clock; must run at least 4x SCLK.
- rst_ni  input  1  asynchronous active-low reset.
- spi_sclk_i  input  1  SPI serial clock, asynchronous.
- spi_cs_ni  input  1  SPI chip select, active-low, asynchronous.
- spi_mosi_i  input  1  SPI data from master, asynchronous.
- spi_miso_o  output  1  SPI data to master; see Optional Feature.
- data_o  output  DATA_W  last completed word; held until the next word completes.
- ack_o  output  1  one-cycle pulse; data_o is valid in the same cycle.
- busy_o  output  1  high while a frame is open (state RECV).
- frame_err_o  output  1  one-cycle pulse when CS deasserts mid-word.

Behaviour:
- Interface: single clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: data_o=0, ack_o=0, busy_o=0, frame_err_o=0, spi_miso_o=0, bit counter=0, shift register=0, state=IDLE.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - One further flop per line gives edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
  - mosi is sampled from the same synchronised stage as sclk, so both see identical delay.
- State IDLE:
  - busy_o=0; all SCLK edges are ignored.
  - On cs_fall: go to RECV, bit_cnt=0, shift register=0.
- State RECV:
  - busy_o=1.
  - On sclk_rise: shift in the synchronised mosi (direction per MSB_FIRST) and increment bit_cnt.
  - When the bit sampled is bit DATA_W-1:
    - Next edge: data_o <= completed word, ack_o=1 for exactly one cycle.
    - bit_cnt wraps to 0 and the state stays RECV, so multi-byte frames need no CS toggle.
- Latency: ack_o rises on the (SYNC_STAGES+2)th clk_i rising edge after the last SCLK rising edge is stable at the pin, +1 cycle synchroniser uncertainty.
- CS rise in RECV with bit_cnt=0: go to IDLE, no error.
- CS rise in RECV with 0 < bit_cnt < DATA_W: discard the partial word, pulse frame_err_o for one cycle, go to IDLE. data_o keeps its old value and ack_o stays 0.
- cs_rise and sclk_rise detected in the same cycle:
  - The sample is taken first.
  - If it completes a word, ack_o pulses, frame_err_o stays 0, and the state goes to IDLE.
  - Otherwise it is treated as a partial word (error, as above).
- cs_fall while already in RECV cannot occur; no action is required.
- ack_o and frame_err_o are never high in the same cycle.
- Reset asserted mid-word: all state clears immediately, with no ack_o or frame_err_o pulse.
- bit_cnt width is $clog2(DATA_W); it never exceeds DATA_W-1.

Optional Feature:
- Macro: SPI_MISO_ECHO_EN.
- With the macro defined:
  - A TX shift register is loaded with the current data_o on cs_fall and after each ack_o.
  - spi_miso_o drives the first-out bit of that register (per MSB_FIRST) combinationally from the register.
  - The register shifts on each sclk_fall while in RECV.
  - In IDLE, spi_miso_o=0.
- Without the macro: spi_miso_o is tied to 0 and no TX logic exists.

Decomposition:
- Package spi_pkg:
  - typedef enum logic {IDLE, RECV} spi_rx_state_e;
  - localparam SPI_DATA_W_DEFAULT=8;
  - localparam SPI_SYNC_MIN=2.
- Sub-module spi_sync:
  - Parameter SYNC_STAGES; async active-low reset to a parameterised reset value (1 for cs_n, 0 otherwise).
  - Outputs the synchronised level plus rise/fall pulses.
  - Instantiated three times.

Test Plan:
- Byte receive: CS low, MSB-first 0xA5 at SCLK = clk/8, CS high -> exactly one ack_o pulse, data_o=0xA5, busy_o returns to 0, frame_err_o never high.
- Multi-byte frame: 0x3C, 0xFF, 0x00 under one CS -> three ack_o pulses with data_o 0x3C, 0xFF, 0x00 in order; busy_o high throughout.
- Aborted word: after 0x5A is received, send 5 bits and then raise CS -> one frame_err_o pulse, no ack_o, data_o still 0x5A.
- Reset mid-word: assert rst_ni low after 4 bits, release, then send 0x81 -> data_o=0 during reset, one ack_o afterwards, data_o=0x81.
- MSB_FIRST=0: send bit sequence 1,0,0,0,0,0,0,0 -> data_o=0x01.
- SPI_MISO_ECHO_EN: after 0xC3 is received, next frame captures MISO on SCLK rising edges -> 0xC3 read back MSB-first; without the macro, MISO stays 0.
